// File: rtl/io_arbiter_pkg.sv
// io_arbiter_pkg: shared widths, IO register map and arbiter FSM states
package io_arbiter_pkg;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam logic [ADDR_W-1:0] IO_IN_ADDR  = 32'h0000_0000;
  localparam logic [ADDR_W-1:0] IO_OUT_ADDR = 32'h0000_0004;
  typedef enum logic [1:0] {ARB_IDLE, ARB_ACCESS, ARB_RESP} arb_state_e;
endpackage

// File: rtl/io_arbiter_if.sv
// io_arbiter_if: two requester ports plus the single IO block port
interface io_arbiter_if;
  import io_arbiter_pkg::*;
  logic              m0_req, m1_req, m0_we, m1_we;
  logic [ADDR_W-1:0] m0_addr, m1_addr;
  logic [DATA_W-1:0] m0_wd, m1_wd;
  logic              m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
  logic [DATA_W-1:0] m0_rdata, m1_rdata;
  logic              io_we;
  logic [ADDR_W-1:0] io_addr;
  logic [DATA_W-1:0] io_wd, io_rd;
  modport master (
    output m0_req, m1_req, m0_we, m1_we, m0_addr, m1_addr, m0_wd, m1_wd, io_rd,
    input  m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_rdata, m1_rdata, io_we, io_addr, io_wd
  );
  modport slave (
    input  m0_req, m1_req, m0_we, m1_we, m0_addr, m1_addr, m0_wd, m1_wd, io_rd,
    output m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_rdata, m1_rdata, io_we, io_addr, io_wd
  );
endinterface

// File: rtl/io_arbiter_rr_arb2.sv
// rr_arb2: combinational two-way round-robin pick; a tie goes to the master that did not win last
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       win,
  output logic       valid
);
  always_comb begin
    win   = &req ? ~last : req[1];
    valid = |req;
  end
endmodule

// File: rtl/io_arbiter.sv
// io_arbiter: serialises two masters onto the IO block, 3 cycles per access (IDLE/ACCESS/RESP)
module io_arbiter
  import io_arbiter_pkg::*;
(
  input logic     clk,
  input logic     rstn,
  io_arbiter_if.slave bus
);
  arb_state_e        state_q;
  logic              last_q, id_q, io_we_q, win, valid;
  logic [1:0]        gnt_q, rvalid_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wd_q;
  rr_arb2 u_rr (.req({bus.m1_req, bus.m0_req}), .last(last_q), .win(win), .valid(valid));
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q  <= ARB_IDLE;
      last_q   <= 1'b1;
      id_q     <= 1'b0;
      io_we_q  <= 1'b0;
      gnt_q    <= '0;
      rvalid_q <= '0;
      addr_q   <= '0;
      wd_q     <= '0;
    end else begin
      gnt_q    <= '0;
      rvalid_q <= '0;
      io_we_q  <= 1'b0;
      case (state_q)
        ARB_IDLE: if (valid) begin
          id_q    <= win;
          last_q  <= win;
          addr_q  <= win ? bus.m1_addr : bus.m0_addr;
          wd_q    <= win ? bus.m1_wd : bus.m0_wd;
          io_we_q <= win ? bus.m1_we : bus.m0_we;
          gnt_q   <= win ? 2'b10 : 2'b01;
          state_q <= ARB_ACCESS;
        end
        ARB_ACCESS: begin
          rvalid_q <= id_q ? 2'b10 : 2'b01;
          state_q  <= ARB_RESP;
        end
        default: state_q <= ARB_IDLE;
      endcase
    end
  end
  // rdata is gated so each master only ever sees IO data during its own RESP
  assign bus.m0_gnt    = gnt_q[0];
  assign bus.m1_gnt    = gnt_q[1];
  assign bus.m0_rvalid = rvalid_q[0];
  assign bus.m1_rvalid = rvalid_q[1];
  assign bus.m0_rdata  = rvalid_q[0] ? bus.io_rd : '0;
  assign bus.m1_rdata  = rvalid_q[1] ? bus.io_rd : '0;
  assign bus.io_we     = io_we_q;
  assign bus.io_addr   = addr_q;
  assign bus.io_wd     = wd_q;
endmodule

// File: tb/tb_io_arbiter.sv
// tb_io_arbiter: directed checks of io_arbiter against a behavioural IO register block
module tb_io_arbiter;
  import io_arbiter_pkg::*;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic [DATA_W-1:0] io_in = 32'h1234_5678;
  logic [DATA_W-1:0] out_reg;
  int n_cmp = 0;
  int n_err = 0;
  io_arbiter_if bus ();
  io_arbiter dut (.clk(clk), .rstn(rstn), .bus(bus));
  always #5 clk = ~clk;
  // IO block: registered read, one writable register, unmapped reads return 0
  always_ff @(posedge clk) begin
    if (!rstn) begin
      out_reg    <= '0;
      bus.io_rd  <= '0;
    end else begin
      bus.io_rd <= bus.io_addr == IO_IN_ADDR ? io_in : bus.io_addr == IO_OUT_ADDR ? out_reg : '0;
      if (bus.io_we && bus.io_addr == IO_OUT_ADDR) out_reg <= bus.io_wd;
    end
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic set_req(input logic m, input logic req, input logic we, input logic [31:0] addr, input logic [31:0] wd);
    if (m) begin
      bus.m1_req = req; bus.m1_we = we; bus.m1_addr = addr; bus.m1_wd = wd;
    end else begin
      bus.m0_req = req; bus.m0_we = we; bus.m0_addr = addr; bus.m0_wd = wd;
    end
  endtask
  // one full transaction from an idle arbiter: IDLE, ACCESS (gnt), RESP (rvalid)
  task automatic do_access(input string tag, input logic m, input logic we, input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] exp);
    @(posedge clk); #1;
    set_req(m, 1'b1, we, addr, wd);
    @(negedge clk);
    chk({tag, ".idle_gnt"}, {30'd0, bus.m1_gnt, bus.m0_gnt}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk({tag, ".gnt"}, {30'd0, bus.m1_gnt, bus.m0_gnt}, m ? 32'd2 : 32'd1);
    chk({tag, ".io_we"}, {31'd0, bus.io_we}, {31'd0, we});
    chk({tag, ".io_addr"}, bus.io_addr, addr);
    if (we) chk({tag, ".io_wd"}, bus.io_wd, wd);
    @(posedge clk); #1;
    set_req(m, 1'b0, 1'b0, 32'd0, 32'd0);
    @(negedge clk);
    chk({tag, ".rvalid"}, {30'd0, bus.m1_rvalid, bus.m0_rvalid}, m ? 32'd2 : 32'd1);
    chk({tag, ".rdata"}, m ? bus.m1_rdata : bus.m0_rdata, exp);
    chk({tag, ".other_rdata"}, m ? bus.m0_rdata : bus.m1_rdata, 32'd0);
    chk({tag, ".resp_we"}, {31'd0, bus.io_we}, 32'd0);
  endtask
  initial begin
    set_req(1'b0, 1'b1, 1'b0, IO_IN_ADDR, 32'd0);
    set_req(1'b1, 1'b1, 1'b0, IO_IN_ADDR, 32'd0);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("rst.gnt", {30'd0, bus.m1_gnt, bus.m0_gnt}, 32'd0);
      chk("rst.rvalid", {30'd0, bus.m1_rvalid, bus.m0_rvalid}, 32'd0);
      chk("rst.rdata", bus.m0_rdata | bus.m1_rdata, 32'd0);
      chk("rst.io_we", {31'd0, bus.io_we}, 32'd0);
    end
    @(posedge clk); #1;
    rstn = 1'b1;
    // both masters keep requesting: m0 wins the first tie, then strict alternation
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      chk("rr.gnt0", {31'd0, bus.m0_gnt}, k % 6 == 1 ? 32'd1 : 32'd0);
      chk("rr.gnt1", {31'd0, bus.m1_gnt}, k % 6 == 4 ? 32'd1 : 32'd0);
      chk("rr.rdata0", bus.m0_rdata, k % 6 == 2 ? io_in : 32'd0);
      chk("rr.rdata1", bus.m1_rdata, k % 6 == 5 ? io_in : 32'd0);
    end
    set_req(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    set_req(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
    do_access("wr4", 1'b0, 1'b1, IO_OUT_ADDR, 32'hDEAD_BEEF, 32'h0);
    do_access("rd4", 1'b0, 1'b0, IO_OUT_ADDR, 32'h0, 32'hDEAD_BEEF);
    do_access("rd0_m1", 1'b1, 1'b0, IO_IN_ADDR, 32'h0, 32'h1234_5678);
    do_access("rd8", 1'b1, 1'b0, 32'h8, 32'h0, 32'h0);
    do_access("wr8", 1'b1, 1'b1, 32'h8, 32'h5555_5555, 32'h0);
    do_access("rd4_after8", 1'b0, 1'b0, IO_OUT_ADDR, 32'h0, 32'hDEAD_BEEF);
    @(posedge clk); #1;
    set_req(1'b0, 1'b1, 1'b1, IO_OUT_ADDR, 32'hA5A5_A5A5);
    @(posedge clk); #1;
    rstn = 1'b0;
    set_req(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    @(negedge clk);
    chk("midrst.gnt", {31'd0, bus.m0_gnt}, 32'd1);
    @(posedge clk); #1;
    rstn = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("midrst.rvalid", {30'd0, bus.m1_rvalid, bus.m0_rvalid}, 32'd0);
      chk("midrst.io_we", {31'd0, bus.io_we}, 32'd0);
    end
    do_access("midrst.rd4", 1'b0, 1'b0, IO_OUT_ADDR, 32'h0, 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
